// File: rtl/sequence_letter_streamer_if.sv
// Letter stream handshake between the sequence reader and the systolic array.
// The master drives the letter and its tags; the slave returns ready.
interface sequence_letter_streamer_if #(
  parameter int LETTER_WIDTH = 2,
  parameter int IDX_W        = 5
);
  logic [LETTER_WIDTH-1:0] letter_out;
  logic                    letter_valid;
  logic                    letter_ready;
  logic [IDX_W-1:0]        letter_idx;
  logic                    letter_last;

  modport master (
    output letter_out,
    output letter_valid,
    input  letter_ready,
    output letter_idx,
    output letter_last
  );

  modport slave (
    input  letter_out,
    input  letter_valid,
    output letter_ready,
    input  letter_idx,
    input  letter_last
  );
endinterface

// File: rtl/sequence_letter_streamer.sv
// Snapshots one sequence bank and streams it out one 2-bit letter per
// transfer; register 0 first, MSB letter of each register first.
module sequence_letter_streamer #(
  parameter int NUM_REG      = 8,
  parameter int BITS_REG     = 8,
  parameter int LETTER_WIDTH = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [NUM_REG-1:0][BITS_REG-1:0]   seq_in,
  sequence_letter_streamer_if.master         stream,
  output logic                               busy,
  output logic                               done
);

  localparam int LPR   = BITS_REG / LETTER_WIDTH;
  localparam int TOTAL = NUM_REG * LPR;
  localparam int IDX_W = $clog2(TOTAL);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]                       state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [NUM_REG-1:0][BITS_REG-1:0] shadow_q, shadow_d;

  logic [LETTER_WIDTH-1:0] letters [TOTAL];
  logic                    st_idle;
  logic                    st_stream;
  logic                    st_done;
  logic                    xfer;
  logic                    is_last;

  // Flat letter view of the shadow bank, in stream order.
  for (genvar r = 0; r < NUM_REG; r++) begin : g_reg
    for (genvar p = 0; p < LPR; p++) begin : g_let
      assign letters[r*LPR+p] =
        shadow_q[r][BITS_REG-1-p*LETTER_WIDTH -: LETTER_WIDTH];
    end
  end

  assign st_idle   = (state_q == S_IDLE);
  assign st_stream = (state_q == S_STREAM);
  assign st_done   = (state_q == S_DONE);

  assign xfer    = st_stream && stream.letter_ready;
  assign is_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    unique case (1'b1)
      st_idle: begin
        if (start && !abort) begin
          shadow_d = seq_in;
          idx_d    = '0;
          state_d  = S_STREAM;
        end
      end
      st_stream: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      st_done: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  // Letter tags are forced to zero outside STREAM.
  assign stream.letter_valid = st_stream;
  assign stream.letter_out   = st_stream ? letters[idx_q] : '0;
  assign stream.letter_idx   = st_stream ? idx_q : '0;
  assign stream.letter_last  = st_stream && is_last;

  assign busy = st_stream;
  assign done = st_done;

endmodule

// File: tb/tb_sequence_letter_streamer.sv
// Directed bench for sequence_letter_streamer: full stream, backpressure,
// snapshot, abort, mid-stream reset and ignored start pulses.
module tb_sequence_letter_streamer;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic [7:0][7:0] seq_in;
  logic busy;
  logic done;

  int checks;
  int failures;

  logic [1:0] exp_let [32];
  logic [7:0][7:0] bank;

  sequence_letter_streamer_if #(.LETTER_WIDTH(2), .IDX_W(5)) lif ();

  sequence_letter_streamer #(
    .NUM_REG(8),
    .BITS_REG(8),
    .LETTER_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .seq_in(seq_in),
    .stream(lif.master),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_valid"}, 32'(lif.letter_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_idx"}, 32'(lif.letter_idx), 0);
    chk({tag, "_out"}, 32'(lif.letter_out), 0);
    chk({tag, "_last"}, 32'(lif.letter_last), 0);
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    seq_in = bank;
    start = 1'b1;
    chk({tag, "_pre_valid"}, 32'(lif.letter_valid), 0);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_lat1_valid"}, 32'(lif.letter_valid), 1);
  endtask

  // Called at the negedge after start was sampled; walks the stream,
  // optionally stalling, refilling seq_in or pulsing start.
  task automatic run_stream(input string tag, input int stall_at,
                            input int stall_n, input bit rewrite,
                            input int pulse_at, input int exp_cyc);
    int k;
    int cyc;
    int stall;
    int guard;
    bit pulsed;
    k = 0; cyc = 0; stall = 0; guard = 0; pulsed = 0;
    while (k < 32 && guard < 200) begin
      guard++;
      if (!lif.letter_valid) begin
        chk({tag, "_valid_drop"}, 32'(lif.letter_valid), 1);
        break;
      end
      cyc++;
      if (rewrite && cyc == 2) seq_in = {8{8'hFF}};
      chk({tag, "_idx"}, 32'(lif.letter_idx), 32'(k));
      chk({tag, "_let"}, 32'(lif.letter_out), 32'(exp_let[k]));
      chk({tag, "_last"}, 32'(lif.letter_last), 32'(k == 31));
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_nodone"}, 32'(done), 0);
      start = (k == pulse_at && !pulsed);
      if (start) pulsed = 1;
      if (k == stall_at && stall < stall_n) begin
        lif.letter_ready = 1'b0;
        stall++;
      end else begin
        lif.letter_ready = 1'b1;
        k++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    lif.letter_ready = 1'b1;
    if (guard >= 200) chk({tag, "_timeout"}, 32'(guard), 0);
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_done_valid"}, 32'(lif.letter_valid), 0);
    chk({tag, "_done_busy"}, 32'(busy), 0);
  endtask

  task automatic advance_to(input string tag, input int target);
    int guard;
    guard = 0;
    while (lif.letter_idx != 5'(target) && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    chk({tag, "_reach"}, 32'(lif.letter_idx), 32'(target));
    chk({tag, "_reach_let"}, 32'(lif.letter_out), 32'(exp_let[target]));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    seq_in = '0;
    lif.letter_ready = 1'b1;

    // Hand-decoded letters of the test bank.
    for (int i = 0; i < 32; i++) exp_let[i] = 2'd0;
    exp_let[0] = 2'd2; exp_let[1] = 2'd1; exp_let[2] = 2'd3; exp_let[3] = 2'd0;
    exp_let[4] = 2'd3; exp_let[5] = 2'd0; exp_let[6] = 2'd2; exp_let[7] = 2'd0;
    exp_let[28] = 2'd1; exp_let[29] = 2'd1;
    exp_let[30] = 2'd2; exp_let[31] = 2'd2;
    bank = '0;
    bank[0] = 8'b10011100;
    bank[1] = 8'b11001000;
    bank[7] = 8'b01011010;

    repeat (2) @(negedge clk);
    outs_zero("rst");
    rst_n = 1'b1;

    // 1: plain stream, ready tied high
    do_start("t1");
    run_stream("t1", -1, 0, 0, -1, 32);
    @(negedge clk);
    chk("t1_done_once", 32'(done), 0);

    // 2: three-cycle stall at idx 5
    do_start("t2");
    run_stream("t2", 5, 3, 0, -1, 35);
    @(negedge clk);
    chk("t2_done_once", 32'(done), 0);

    // 3: bank refilled with all-ones after start
    do_start("t3");
    run_stream("t3", -1, 0, 1, -1, 32);
    @(negedge clk);
    seq_in = bank;

    // 4: abort at idx 10, then restart from idx 0
    do_start("t4");
    advance_to("t4", 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_valid", 32'(lif.letter_valid), 0);
    chk("t4_abort_busy", 32'(busy), 0);
    chk("t4_abort_done", 32'(done), 0);
    @(negedge clk);
    chk("t4_abort_done2", 32'(done), 0);
    do_start("t4r");
    run_stream("t4r", -1, 0, 0, -1, 32);
    @(negedge clk);

    // 5: reset at idx 17, then start+abort together
    do_start("t5");
    advance_to("t5", 17);
    rst_n = 1'b0;
    @(negedge clk);
    outs_zero("t5_rst");
    rst_n = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t5_sa_valid", 32'(lif.letter_valid), 0);
    chk("t5_sa_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t5_sa_valid2", 32'(lif.letter_valid), 0);

    // 6: start pulses inside STREAM and in the DONE cycle
    do_start("t6");
    run_stream("t6", -1, 0, 0, 3, 32);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_post_done", 32'(done), 0);
    chk("t6_post_valid", 32'(lif.letter_valid), 0);
    chk("t6_post_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t6_idle_valid", 32'(lif.letter_valid), 0);
    chk("t6_idle_done", 32'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_letter_streamer.md
Name: sequence_letter_streamer

Overview:
Reader side of the sequence buffer. It snapshots one buffered sequence bank (NUM_REG registers of BITS_REG bits, each register holding packed 2-bit letters). It then streams the bank out one letter per transfer, over a valid/ready handshake, to the systolic alignment array. The controller starts it and receives a one-cycle done pulse when the last letter has been accepted.

Parameters:
- NUM_REG, 8, number of buffer registers in the bank.
- BITS_REG, 8, bits per buffer register.
- LETTER_WIDTH, 2, bits per letter (A/C/G/T code).
- Derived, not overridable: LPR = BITS_REG/LETTER_WIDTH (letters per register, 4). TOTAL = NUM_REG*LPR (32). IDX_W = $clog2(TOTAL) (5).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  controller request; sampled only in IDLE.
- abort  in  1  controller abort; returns the block to IDLE.
- seq_in  in  [NUM_REG-1:0][BITS_REG-1:0]  parallel bank from sequence_buffer.
- letter_out  out  LETTER_WIDTH  current letter.
- letter_valid  out  1  letter_out/letter_idx/letter_last are valid.
- letter_ready  in  1  consumer accepts the letter when high together with letter_valid.
- letter_idx  out  IDX_W  index of the current letter, 0..TOTAL-1.
- letter_last  out  1  high with the final letter (idx TOTAL-1).
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - All outputs are 0.
  - Shadow register and index counter are cleared.
  - Reset overrides everything, including an in-progress stream.
- FSM has three states: IDLE, STREAM, DONE.
- IDLE:
  - letter_valid=0, busy=0.
  - If start=1 (and abort=0): capture seq_in into the internal shadow bank, clear idx to 0, and go to STREAM.
  - Letter 0 is presented the cycle after start is sampled (latency 1).
- STREAM:
  - busy=1, letter_valid=1.
  - letter_out = shadow[idx/LPR][BITS_REG-1-(idx%LPR)*LETTER_WIDTH -: LETTER_WIDTH]. Register 0 goes first; within a register the MSB letter goes first.
  - A transfer occurs when letter_valid && letter_ready. On a transfer, idx increments.
  - While letter_ready=0, letter_out, letter_idx and letter_last hold stable.
  - letter_last=1 iff idx==TOTAL-1.
  - A transfer with letter_last=1 moves the FSM to DONE and does not wrap idx.
  - Throughput is 1 letter/cycle; with letter_ready tied high, all TOTAL letters go out in TOTAL consecutive cycles.
- DONE:
  - done=1 for exactly one cycle; letter_valid=0, busy=0.
  - Next state is IDLE unconditionally.
  - A start asserted in DONE is ignored.
- abort:
  - In STREAM or DONE, abort=1 sends the FSM to IDLE next cycle with letter_valid=0.
  - No done pulse is generated, and any in-flight letter is dropped.
  - abort and start together in IDLE: abort wins and the FSM stays in IDLE.
- Snapshot: seq_in changes after start is sampled do not affect the stream. The buffer may be refilled during STREAM.
- start while busy is ignored; no queuing.
- letter_idx, letter_out and letter_last read 0 whenever letter_valid=0.

Test Plan:
1. Reset, then start=1 for one cycle with seq_in[0]=8'b10011100, seq_in[1]=8'b11001000, seq_in[7]=8'b01011010, other registers 0, and letter_ready=1.
   - Required: letter_valid rises 1 cycle after start.
   - Letters 2,1,3,0 with idx 0..3, then 3,0,2,0 with idx 4..7.
   - Final letters 1,1,2,2 at idx 28..31, with letter_last=1 only at idx 31.
   - done pulses one cycle after idx 31 is accepted; busy is high for exactly 32 cycles.
2. Backpressure: same bank; letter_ready=0 for 3 cycles at idx 5.
   - Required: letter_out=0 and idx=5 held stable for all 3 cycles, no skipped or duplicated letters, and completion takes 35 cycles.
3. Snapshot: after start, rewrite all seq_in registers to 8'hFF.
   - Required: the stream still matches the original bank and never emits letter 3 from the new data.
4. Abort at idx 10.
   - Required: letter_valid=0 and busy=0 the next cycle, with no done pulse.
   - A subsequent start restarts from idx 0.
5. Reset mid-stream (rst_n=0 at idx 17).
   - Required: all outputs 0 after the edge and the FSM in IDLE.
   - start with abort=1 in the same cycle gives no stream.
6. Start pulses asserted during STREAM and during the DONE cycle.
   - Required: both ignored, exactly one done pulse, and the block returns to IDLE.
